seq_divider: RTL



---
 rtl/seq_divider_if.sv | 26 ++
 rtl/seq_divider.sv | 117 +++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// seq_divider_if: operand/result bundle for the sequential divider.
//   master: drives start, dividend, divisor; observes busy, done and results.
//   slave : the divider itself.
interface seq_divider_if #(
   parameter int unsigned DIVIDEND_W = 8,
   parameter int unsigned DIVISOR_W  = 4
);
   logic                  start;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic                  busy;
   logic                  done;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one subtract-and-compare per clock.
//   Clock      : system clock, rising edge.
//   Resetn     : asynchronous active-low reset.
//   bus_io     : slave side of seq_divider_if
//                  start/dividend/divisor in; busy, done (1-cycle pulse),
//                  quotient, remainder, div_by_zero out.
// A nonzero division takes DIVIDEND_W RUN cycles then one DONE cycle; a zero divisor
// goes straight to DONE with quotient all ones.
module seq_divider #(
   parameter int unsigned DIVIDEND_W = 8,
   parameter int unsigned DIVISOR_W  = 4
) (
   input logic         Clock,
   input logic         Resetn,
   seq_divider_if.slave bus_io
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam int unsigned CntW = $clog2(DIVIDEND_W + 1);

   logic [1:0]            state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [DIVIDEND_W-1:0] work_q, work_d;    // shifting dividend / forming quotient
   logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
   logic [DIVISOR_W-1:0]  rem_q, rem_d;      // partial remainder
   logic [DIVIDEND_W-1:0] quot_q, quot_d;    // visible results, updated only at completion
   logic [DIVISOR_W-1:0]  remd_q, remd_d;
   logic                  dbz_q, dbz_d;

   logic [DIVISOR_W:0]    p;
   logic [DIVISOR_W-1:0]  diff;
   logic                  ge;

   // Partial remainder is always < divisor, so {R, Q msb} fits in DIVISOR_W+1 bits and
   // the difference, when taken, fits back into DIVISOR_W bits.
   always_comb begin
      p    = {rem_q, work_q[DIVIDEND_W-1]};
      ge   = (p >= {1'b0, dvs_q});
      diff = p[DIVISOR_W-1:0] - dvs_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      remd_d  = remd_q;
      dbz_d   = dbz_q;

      case (state_q)
         StRun: begin
            rem_d  = ge ? diff : p[DIVISOR_W-1:0];
            work_d = {work_q[DIVIDEND_W-2:0], ge};
            cnt_d  = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               state_d = StDone;
               quot_d  = work_d;
               remd_d  = rem_d;
            end
         end
         default: begin
            // Idle and Done accept a new start identically (back-to-back support).
            if (bus_io.start) begin
               if (bus_io.divisor == '0) begin
                  state_d = StDone;
                  quot_d  = '1;
                  remd_d  = '0;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = StRun;
                  work_d  = bus_io.dividend;
                  dvs_d   = bus_io.divisor;
                  rem_d   = '0;
                  cnt_d   = CntW'(DIVIDEND_W);
                  dbz_d   = 1'b0;
               end
            end else begin
               state_d = StIdle;
            end
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         work_q  <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         remd_q  <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         remd_q  <= remd_d;
         dbz_q   <= dbz_d;
      end
   end

   assign bus_io.busy        = (state_q == StRun);
   assign bus_io.done        = (state_q == StDone);
   assign bus_io.quotient    = quot_q;
   assign bus_io.remainder   = remd_q;
   assign bus_io.div_by_zero = dbz_q;

endmodule
